// File: rtl/snitch_dreq_responder.sv
// Memory-side terminator of the Snitch dreq/dresp interface in front of one 1-cycle SRAM bank.
// Define SNITCH_DREQ_RESPONDER_AMO_EN to add atomic memory operations (AMO_WB state).
package snitch_dreq_responder_pkg;
  localparam int unsigned IdWidth = 6;

  localparam logic [3:0] AMO_NONE = 4'd0;
  localparam logic [3:0] AMO_SWAP = 4'd1;
  localparam logic [3:0] AMO_ADD  = 4'd2;
  localparam logic [3:0] AMO_AND  = 4'd3;
  localparam logic [3:0] AMO_OR   = 4'd4;
  localparam logic [3:0] AMO_XOR  = 4'd5;
  localparam logic [3:0] AMO_MAX  = 4'd6;
  localparam logic [3:0] AMO_MAXU = 4'd7;
  localparam logic [3:0] AMO_MIN  = 4'd8;
  localparam logic [3:0] AMO_MINU = 4'd9;

  typedef struct packed {
    logic [31:0]        addr;
    logic [IdWidth-1:0] id;
    logic [3:0]         amo;
    logic               write;
    logic [31:0]        data;
    logic [3:0]         strb;
  } dreq_t;

  typedef struct packed {
    logic [31:0]        data;
    logic [IdWidth-1:0] id;
    logic               write;
    logic               error;
  } dresp_t;
endpackage

module snitch_dreq_responder
  import snitch_dreq_responder_pkg::*;
#(
  parameter int unsigned MemAddrWidth = 10,
  parameter int unsigned RespDepth    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  dreq_t                   dreq_q_i,
  input  logic                    dreq_q_valid_i,
  output logic                    dreq_q_ready_o,
  output dresp_t                  dresp_p_o,
  output logic                    dresp_p_valid_o,
  input  logic                    dresp_p_ready_i,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [31:0]             mem_wdata_o,
  output logic [3:0]              mem_be_o,
  input  logic [31:0]             mem_rdata_i
);
  localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CntW = $clog2(RespDepth + 1) + 1;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

`ifdef SNITCH_DREQ_RESPONDER_AMO_EN
  typedef enum logic {IDLE, AMO_WB} state_e;
`else
  typedef enum logic {IDLE} state_e;
`endif

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(RespDepth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  logic   active_reg;
  state_e state_reg;
  cnt_t   fifo_cnt_reg;
  ptr_t   wr_ptr_reg;
  ptr_t   rd_ptr_reg;
  dresp_t fifo_mem [RespDepth];
  logic   pend_valid_reg;
  logic   pend_rdata_reg;
  dresp_t pend_resp_reg;

  logic                    credit_ok;
  logic                    accept;
  logic                    addr_err;
  logic                    amo_req;
  logic                    amo_err;
  logic                    req_err;
  logic                    push;
  logic                    pop;
  logic [MemAddrWidth-1:0] word_addr;
  dresp_t                  push_resp;
  logic                    unused_addr_lsb;

  // Count the request sitting in the SRAM read stage so the FIFO can never overflow.
  assign credit_ok      = (fifo_cnt_reg + cnt_t'(pend_valid_reg)) < cnt_t'(RespDepth);
  assign dreq_q_ready_o = active_reg && (state_reg == IDLE) && credit_ok;
  assign accept         = dreq_q_valid_i && dreq_q_ready_o;

  assign addr_err        = (dreq_q_i.addr >> (MemAddrWidth + 2)) != 32'd0;
  assign word_addr       = dreq_q_i.addr[MemAddrWidth+1:2];
  assign unused_addr_lsb = ^dreq_q_i.addr[1:0];
  assign amo_req         = dreq_q_i.amo != AMO_NONE;
`ifdef SNITCH_DREQ_RESPONDER_AMO_EN
  assign amo_err = dreq_q_i.amo > AMO_MINU;
`else
  assign amo_err = amo_req;
`endif
  assign req_err = addr_err || amo_err;

`ifdef SNITCH_DREQ_RESPONDER_AMO_EN
  logic [3:0]              amo_op_reg;
  logic [31:0]             amo_operand_reg;
  logic [MemAddrWidth-1:0] amo_addr_reg;
  logic [31:0]             amo_result;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      amo_op_reg      <= AMO_NONE;
      amo_operand_reg <= '0;
      amo_addr_reg    <= '0;
    end else if (accept) begin
      amo_op_reg      <= dreq_q_i.amo;
      amo_operand_reg <= dreq_q_i.data;
      amo_addr_reg    <= word_addr;
    end
  end

  // Old value arrives from the SRAM during AMO_WB; the result is written back in that cycle.
  always_comb begin
    amo_result = amo_operand_reg;
    case (amo_op_reg)
      AMO_SWAP: amo_result = amo_operand_reg;
      AMO_ADD:  amo_result = mem_rdata_i + amo_operand_reg;
      AMO_AND:  amo_result = mem_rdata_i & amo_operand_reg;
      AMO_OR:   amo_result = mem_rdata_i | amo_operand_reg;
      AMO_XOR:  amo_result = mem_rdata_i ^ amo_operand_reg;
      AMO_MAX:  amo_result = ($signed(mem_rdata_i) > $signed(amo_operand_reg)) ? mem_rdata_i : amo_operand_reg;
      AMO_MAXU: amo_result = (mem_rdata_i > amo_operand_reg) ? mem_rdata_i : amo_operand_reg;
      AMO_MIN:  amo_result = ($signed(mem_rdata_i) < $signed(amo_operand_reg)) ? mem_rdata_i : amo_operand_reg;
      AMO_MINU: amo_result = (mem_rdata_i < amo_operand_reg) ? mem_rdata_i : amo_operand_reg;
      default:  amo_result = amo_operand_reg;
    endcase
  end
`endif

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (accept && !req_err) begin
      mem_req_o  = 1'b1;
      mem_addr_o = word_addr;
      mem_be_o   = 4'hF;
      if (dreq_q_i.write && !amo_req) begin
        mem_we_o    = 1'b1;
        mem_wdata_o = dreq_q_i.data;
        mem_be_o    = dreq_q_i.strb;
      end
    end
`ifdef SNITCH_DREQ_RESPONDER_AMO_EN
    if (state_reg == AMO_WB) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = amo_addr_reg;
      mem_wdata_o = amo_result;
      mem_be_o    = 4'hF;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_reg     <= 1'b0;
      state_reg      <= IDLE;
      pend_valid_reg <= 1'b0;
      pend_rdata_reg <= 1'b0;
      pend_resp_reg  <= '0;
    end else begin
      active_reg     <= 1'b1;
      pend_valid_reg <= accept;
      if (accept) begin
        pend_rdata_reg      <= !req_err && (amo_req || !dreq_q_i.write);
        pend_resp_reg.data  <= '0;
        pend_resp_reg.id    <= dreq_q_i.id;
        pend_resp_reg.write <= !amo_req && dreq_q_i.write;
        pend_resp_reg.error <= req_err;
      end
`ifdef SNITCH_DREQ_RESPONDER_AMO_EN
      case (state_reg)
        IDLE:    if (accept && amo_req && !req_err) state_reg <= AMO_WB;
        default: state_reg <= IDLE;
      endcase
`endif
    end
  end

  always_comb begin
    push_resp = pend_resp_reg;
    if (pend_rdata_reg) push_resp.data = mem_rdata_i;
  end

  assign push            = pend_valid_reg;
  assign dresp_p_valid_o = fifo_cnt_reg != '0;
  assign pop             = dresp_p_valid_o && dresp_p_ready_i;
  // Head is gated by valid so the response bus reads zero whenever the FIFO is empty.
  assign dresp_p_o       = dresp_p_valid_o ? fifo_mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= push_resp;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fifo_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      fifo_cnt_reg <= fifo_cnt_reg + cnt_t'(push) - cnt_t'(pop);
    end
  end
endmodule
